uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin sharing of one UART transmitter among NREQ byte
//             producers, sequencing the transmit/busy handshake per byte.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [7:0]          uart_data,
  output logic                uart_transmit,
  input  logic                uart_busy,
  output logic [IDW-1:0]      grant_id,
  output logic                active,
  output logic                err_timeout
);

  localparam int c_CMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int c_CW   = (c_CMAX < 2) ? 1 : $clog2(c_CMAX);
  localparam logic [c_CW-1:0] c_ACK_LAST = c_CW'(ACK_TIMEOUT - 1);
  localparam logic [c_CW-1:0] c_GAP_LAST = (GAP_CYCLES > 0) ? c_CW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  state_t            r_state;
  logic [IDW-1:0]    r_rr_ptr;
  logic [c_CW-1:0]   r_cnt;
  logic [7:0]        r_data;
  logic [IDW-1:0]    r_gid;
  logic              r_tx;
  logic              r_active;
  logic              r_err;

  logic [2*NREQ-1:0] w_dbl;
  logic              w_found;
  logic [IDW-1:0]    w_winner;
  logic [IDW-1:0]    w_next_ptr;
  logic [NREQ-1:0]   w_onehot;
  logic [7:0]        w_data;
  logic              w_accept;

  // Rotating the doubled request vector by rr_ptr turns the round-robin
  // search into a plain lowest-set-bit search over the first NREQ bits.
  always_comb begin
    w_dbl    = {req_valid, req_valid} >> r_rr_ptr;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_dbl[k]) begin
        w_found  = 1'b1;
        w_winner = IDW'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
    w_next_ptr = IDW'((int'(w_winner) + 1) % NREQ);
  end

  always_comb begin
    w_onehot = '0;
    w_data   = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == IDW'(i)) begin
        w_onehot[i] = 1'b1;
        w_data      = req_data[8*i +: 8];
      end
    end
  end

  // The accept pulse must coincide with the cycle the byte is captured,
  // so it is decoded from the registered state rather than registered itself.
  assign w_accept = (r_state == S_IDLE) && !reset && !uart_busy && w_found;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_data   <= 8'h00;
      r_gid    <= '0;
      r_tx     <= 1'b0;
      r_active <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data   <= w_data;
            r_gid    <= w_winner;
            r_rr_ptr <= w_next_ptr;
            r_tx     <= 1'b1;
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (uart_busy) begin
            r_tx    <= 1'b0;
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == c_ACK_LAST) begin
            r_tx  <= 1'b0;
            r_err <= 1'b1;
            r_cnt <= '0;
            if (GAP_CYCLES == 0) begin
              r_active <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_state <= S_GAP;
            end
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        S_WAIT_DONE: begin
          // No glitch filtering: a single low cycle of busy ends the transfer.
          if (!uart_busy) begin
            r_cnt <= '0;
            if (GAP_CYCLES == 0) begin
              r_active <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_cnt == c_GAP_LAST) begin
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = w_accept ? w_onehot : '0;
  assign uart_data     = r_data;
  assign uart_transmit = r_tx;
  assign grant_id      = r_gid;
  assign active        = r_active;
  assign err_timeout   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Directed table-driven and sequence checks for uart_tx_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  uart_data;
  logic        uart_transmit;
  logic        uart_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_timeout;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .NREQ(4), .IDW(2), .ACK_TIMEOUT(16), .GAP_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_data(uart_data), .uart_transmit(uart_transmit),
    .uart_busy(uart_busy), .grant_id(grant_id), .active(active),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic [3:0] vld;
    logic       busy;
    logic [3:0] e_rdy;
    logic       e_tx;
    logic       e_act;
    logic [1:0] e_gid;
    logic [7:0] e_dat;
    logic       e_err;
  } vec_t;

  vec_t       tbl[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         pend[4];
  int         busy_left;
  bit         no_ack;
  logic [7:0] log_q[$];
  logic [3:0] last_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {15'd0, req_ready, uart_transmit, active, grant_id, uart_data, err_timeout};
  endfunction

  task automatic add(input logic [3:0] v, input logic b, input logic [3:0] r, input logic t,
                     input logic a, input logic [1:0] g, input logic [7:0] d, input logic e);
    vec_t x;
    x.vld = v; x.busy = b; x.e_rdy = r; x.e_tx = t; x.e_act = a;
    x.e_gid = g; x.e_dat = d; x.e_err = e;
    tbl.push_back(x);
  endtask

  // One clock of the requester + usart model: requesters hold valid until
  // accepted; the usart raises busy one cycle after a strobe, for 3 cycles.
  task automatic cycle();
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) req_valid[i] = (pend[i] > 0);
    uart_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
    #3;
    check("ready_legal", 32'(($countones(req_ready) > 1) || ((req_ready & ~req_valid) != 4'b0)), 32'd0);
    last_ready = req_ready;
    for (int i = 0; i < 4; i++) if (req_ready[i]) pend[i]--;
    if (uart_transmit && busy_left == 0 && !uart_busy && !no_ack) begin
      log_q.push_back(uart_data);
      busy_left = 3;
    end
  endtask

  task automatic run_until_logs(input int n, input string name);
    int k = 0;
    while (log_q.size() < n && k < 300) begin
      cycle();
      k++;
    end
    if (log_q.size() < n) check(name, 32'(log_q.size()), 32'(n));
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; req_valid = 4'b0; uart_busy = 1'b0;
    for (int i = 0; i < 4; i++) pend[i] = 0;
    busy_left = 0; no_ack = 1'b0; log_q.delete();
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    int txc, errc, k;
    reset = 1'b1; req_valid = 4'b0; uart_busy = 1'b0; req_data = 32'h13411110;
    for (int i = 0; i < 4; i++) pend[i] = 0;
    busy_left = 0; no_ack = 1'b0;

    // Single request for requester 2, then requester 0, then foreign busy.
    add(4'b0100, 0, 4'b0100, 0, 0, 2'd0, 8'h00, 0);
    add(4'b0000, 0, 4'b0000, 1, 1, 2'd2, 8'h41, 0);
    add(4'b0000, 0, 4'b0000, 1, 1, 2'd2, 8'h41, 0);
    add(4'b0000, 1, 4'b0000, 1, 1, 2'd2, 8'h41, 0);
    add(4'b0000, 1, 4'b0000, 0, 1, 2'd2, 8'h41, 0);
    add(4'b0000, 1, 4'b0000, 0, 1, 2'd2, 8'h41, 0);
    add(4'b0000, 0, 4'b0000, 0, 1, 2'd2, 8'h41, 0);
    add(4'b0001, 0, 4'b0000, 0, 1, 2'd2, 8'h41, 0);
    add(4'b0001, 0, 4'b0000, 0, 1, 2'd2, 8'h41, 0);
    add(4'b0001, 0, 4'b0001, 0, 0, 2'd2, 8'h41, 0);
    add(4'b0000, 1, 4'b0000, 1, 1, 2'd0, 8'h10, 0);
    add(4'b0000, 0, 4'b0000, 0, 1, 2'd0, 8'h10, 0);
    add(4'b0000, 0, 4'b0000, 0, 1, 2'd0, 8'h10, 0);
    add(4'b0000, 0, 4'b0000, 0, 1, 2'd0, 8'h10, 0);
    add(4'b0000, 0, 4'b0000, 0, 0, 2'd0, 8'h10, 0);
    add(4'b0001, 1, 4'b0000, 0, 0, 2'd0, 8'h10, 0);
    add(4'b0001, 0, 4'b0001, 0, 0, 2'd0, 8'h10, 0);
    add(4'b0000, 1, 4'b0000, 1, 1, 2'd0, 8'h10, 0);
    add(4'b0000, 0, 4'b0000, 0, 1, 2'd0, 8'h10, 0);
    add(4'b0000, 0, 4'b0000, 0, 1, 2'd0, 8'h10, 0);
    add(4'b0000, 0, 4'b0000, 0, 1, 2'd0, 8'h10, 0);
    add(4'b0000, 0, 4'b0000, 0, 0, 2'd0, 8'h10, 0);

    repeat (2) @(posedge clock);
    #4 check("reset_values", outs(), 32'd0);

    for (int n = 0; n < tbl.size(); n++) begin
      @(posedge clock); #1;
      reset = 1'b0; req_valid = tbl[n].vld; uart_busy = tbl[n].busy;
      #3;
      check($sformatf("vec%0d", n), outs(),
            {15'd0, tbl[n].e_rdy, tbl[n].e_tx, tbl[n].e_act, tbl[n].e_gid, tbl[n].e_dat, tbl[n].e_err});
    end

    // Fairness with all requesters continuously valid.
    req_data = 32'h13121110;
    do_reset();
    for (int i = 0; i < 4; i++) pend[i] = 2;
    run_until_logs(8, "fair_budget");
    for (int i = 0; i < 8; i++)
      check($sformatf("fair_byte%0d", i), 32'(log_q[i]), 32'(8'h10 + 8'(i % 4)));

    // Pointer wrap: grant 2 leaves rr_ptr=3, then 3 and 0 compete.
    do_reset();
    pend[2] = 1;
    run_until_logs(1, "wrap_prep");
    repeat (8) cycle();
    pend[0] = 1; pend[3] = 1;
    run_until_logs(3, "wrap_budget");
    check("wrap_first", 32'(log_q[1]), 32'h13);
    check("wrap_second", 32'(log_q[2]), 32'h10);
    repeat (8) cycle();
    for (int i = 0; i < 4; i++) pend[i] = 1;
    run_until_logs(4, "wrap_ptr_budget");
    check("wrap_ptr_is_1", 32'(log_q[3]), 32'h11);

    // Timeout: usart never acknowledges requester 1.
    do_reset();
    no_ack = 1'b1; pend[1] = 1;
    k = 0;
    do begin cycle(); k++; end while (last_ready == 4'b0 && k < 10);
    check("to_accept", 32'(last_ready), 32'h2);
    pend[2] = 1;
    txc = 0; errc = 0;
    for (k = 0; k < 60; k++) begin
      cycle();
      txc += int'(uart_transmit);
      errc += int'(err_timeout);
      if (!active) break;
    end
    check("to_tx_cycles", 32'(txc), 32'd16);
    check("to_err_pulses", 32'(errc), 32'd1);
    check("to_next_grant", 32'(last_ready), 32'h4);
    no_ack = 1'b0;
    run_until_logs(1, "to_resume");
    check("to_resume_byte", 32'(log_q[0]), 32'h12);
    repeat (8) cycle();

    // Reset during WAIT_DONE.
    do_reset();
    pend[3] = 1;
    run_until_logs(1, "rst_prep");
    cycle();
    @(posedge clock); #1;
    reset = 1'b1; uart_busy = 1'b1; req_valid = 4'b0001;
    #3 check("rst_in_wait", 32'({active, uart_transmit}), 32'h2);
    @(posedge clock); #1;
    #3 check("rst_outputs", outs(), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; uart_busy = 1'b0; req_valid = 4'b1001;
    for (int i = 0; i < 4; i++) pend[i] = 0;
    busy_left = 0;
    #3 check("rst_grant0", 32'(req_ready), 32'h1);
    repeat (12) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
